// File: rtl/uop_sequencer.sv
// uop_sequencer: parametrised microcode sequencer.
// Selects one of NUM_PROGS entry points, fetches uops from a shared registered
// ROM, issues each one to the executor with valid/ready, waits for uop_done,
// and stops at an OPCODE_RDY word or at the last ROM address.
// Optional issued-uop watchdog: define UOP_SEQ_WATCHDOG_EN.
module uop_sequencer #(
    parameter int unsigned                 UOP_W      = 20,
    parameter int unsigned                 ADDR_W     = 6,
    parameter int unsigned                 OPCODE_W   = 4,
    parameter logic [OPCODE_W-1:0]         OPCODE_RDY = '0,
    parameter int unsigned                 NUM_PROGS  = 4,
    parameter int unsigned                 PROG_ID_W  = 2,
    parameter logic [NUM_PROGS*ADDR_W-1:0] PROG_BASES = {6'd48, 6'd32, 6'd16, 6'd0},
    parameter int unsigned                 WDOG_MAX   = 63
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PROG_ID_W-1:0] prog_id,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [UOP_W-1:0]     rom_data,
    output logic [UOP_W-1:0]     uop,
    output logic                 uop_valid,
    input  logic                 uop_ready,
    input  logic                 uop_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    // The issued-uop counter is 8 bits wide, so the limit has to fit in it.
    if (WDOG_MAX > 255) begin : g_wdog_range
        $error("WDOG_MAX must fit in 8 bits");
    end

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [UOP_W-1:0]    uop_q;
    logic                uop_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [ADDR_W-1:0]   entry_d;
    logic                prog_ok_d;
    logic [ADDR_W-1:0]   pc_inc_d;
    logic                is_rdy_d;

`ifdef UOP_SEQ_WATCHDOG_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_MAX);
    logic [7:0]          wdog_q;
`endif

    // Entry-point lookup; an id with no table entry leaves prog_ok_d low.
    always_comb begin
        entry_d   = '0;
        prog_ok_d = 1'b0;
        for (int unsigned i = 0; i < NUM_PROGS; i++) begin
            if (prog_id == PROG_ID_W'(i)) begin
                entry_d   = PROG_BASES[i*ADDR_W +: ADDR_W];
                prog_ok_d = 1'b1;
            end
        end
    end

    assign pc_inc_d = pc_q + PC_ONE;
    assign is_rdy_d = (rom_data[UOP_W-1 -: OPCODE_W] == OPCODE_RDY);

    // Sequencer FSM with all outputs registered.
    // rom_addr is loaded on entry to FETCH so the ROM read overlaps FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            rom_addr_q  <= '0;
            uop_q       <= '0;
            uop_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef UOP_SEQ_WATCHDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (prog_ok_d) begin
                            pc_q       <= entry_d;
                            rom_addr_q <= entry_d;
                            busy_q     <= 1'b1;
                            state_q    <= S_FETCH;
`ifdef UOP_SEQ_WATCHDOG_EN
                            wdog_q     <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    rom_addr_q <= pc_q;
                    state_q    <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_rdy_d) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
`ifdef UOP_SEQ_WATCHDOG_EN
                    else if (wdog_q >= WDOG_LIMIT) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
`endif
                    else begin
                        uop_q       <= rom_data;
                        uop_valid_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (uop_ready) begin
                        uop_valid_q <= 1'b0;
                        state_q     <= S_WAIT;
`ifdef UOP_SEQ_WATCHDOG_EN
                        wdog_q      <= wdog_q + 8'd1;
`endif
                    end
                end
                S_WAIT: begin
                    if (uop_done) begin
                        if (pc_q == '1) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            pc_q       <= pc_inc_d;
                            rom_addr_q <= pc_inc_d;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rom_addr  = rom_addr_q;
    assign uop       = uop_q;
    assign uop_valid = uop_valid_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Testbench for uop_sequencer: directed program runs checked against a table
// of hand-computed results, plus stall, re-start, reset and id-range sequences.
module tb_uop_sequencer;

    localparam logic [19:0] U0   = 20'h1_00A0;
    localparam logic [19:0] U1   = 20'h2_00B1;
    localparam logic [19:0] U2   = 20'h3_00C2;
    localparam logic [19:0] U16  = 20'h5_1616;
    localparam logic [19:0] U60  = 20'h7_003C;
    localparam logic [19:0] U63  = 20'h7_003F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, busy, done, err, uop_valid, uop_ready, uop_done;
    logic [1:0]  prog_id;
    logic [5:0]  rom_addr;
    logic [19:0] rom_data, uop;
    logic        exec_done, force_done;
    logic [19:0] rom [64];

    logic        start2, busy2, done2, err2, uop_valid2, uop_ready2, uop_done2;
    logic [1:0]  prog_id2;
    logic [5:0]  rom_addr2;
    logic [19:0] rom_data2, uop2;

    uop_sequencer #(
        .PROG_BASES({6'd60, 6'd32, 6'd16, 6'd0})
    ) dut (
        .clk(clk), .rst(rst), .start(start), .prog_id(prog_id),
        .busy(busy), .done(done), .err(err),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .uop(uop), .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_done(uop_done)
    );

    uop_sequencer #(
        .NUM_PROGS(3),
        .PROG_BASES({6'd32, 6'd16, 6'd0})
    ) dut_np3 (
        .clk(clk), .rst(rst), .start(start2), .prog_id(prog_id2),
        .busy(busy2), .done(done2), .err(err2),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .uop(uop2), .uop_valid(uop_valid2), .uop_ready(uop_ready2), .uop_done(uop_done2)
    );

    always @(posedge clk) rom_data  <= rom[rom_addr];
    always @(posedge clk) rom_data2 <= rom[rom_addr2];
    // Executor model: completes each accepted uop one cycle after acceptance.
    always @(posedge clk) exec_done <= !rst && uop_valid && uop_ready;
    assign uop_done = exec_done | force_done;

`ifdef UOP_SEQ_WATCHDOG_EN
    logic        start3, busy3, done3, err3, uop_valid3, uop_ready3, exec_done3;
    logic [1:0]  prog_id3;
    logic [5:0]  rom_addr3;
    logic [19:0] rom_data3, uop3;
    int          issued3 = 0;

    uop_sequencer #(
        .WDOG_MAX(2)
    ) dut_wd (
        .clk(clk), .rst(rst), .start(start3), .prog_id(prog_id3),
        .busy(busy3), .done(done3), .err(err3),
        .rom_addr(rom_addr3), .rom_data(rom_data3),
        .uop(uop3), .uop_valid(uop_valid3), .uop_ready(uop_ready3), .uop_done(exec_done3)
    );

    always @(posedge clk) rom_data3  <= rom[rom_addr3];
    always @(posedge clk) exec_done3 <= !rst && uop_valid3 && uop_ready3;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          both_cnt = 0;
    logic [19:0] issued [$];

    typedef struct {
        int          n;
        logic [19:0] fu, lu;
        logic        d, e, busy1, zero_seen, post_clear;
        int          fk, tk;
        logic [5:0]  ae;
    } res_t;

    typedef struct {
        logic [1:0]  id;
        int          n;
        logic [19:0] fu, lu;
        logic        d, e;
        int          fk, tk;
        logic        z;
        logic [5:0]  ae;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Record what the current cycle shows, then advance to the next negedge.
    task automatic tick();
        if (uop_valid === 1'b1 && uop_ready && !rst) issued.push_back(uop);
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (done === 1'b1 && err === 1'b1) both_cnt++;
`ifdef UOP_SEQ_WATCHDOG_EN
        if (uop_valid3 === 1'b1 && uop_ready3 && !rst) issued3++;
`endif
        @(negedge clk);
    endtask

    // Start program id; optionally pulse start (prog 2) again at cycle inj_k.
    task automatic run_prog(input logic [1:0] id, input int inj_k, output res_t r);
        int n0, k;
        r.n = 0; r.fu = '0; r.lu = '0; r.d = 0; r.e = 0; r.busy1 = 0;
        r.zero_seen = 0; r.post_clear = 0; r.fk = 0; r.tk = 0; r.ae = '0;
        n0 = issued.size();
        start = 1'b1; prog_id = id;
        tick();
        start = 1'b0;
        k = 1;
        r.busy1 = busy;
        while (r.tk == 0 && k < 200) begin
            if (k == inj_k) begin start = 1'b1; prog_id = 2'd2; end
            else start = 1'b0;
            if (rom_addr == 6'd0) r.zero_seen = 1'b1;
            if (uop_valid && r.fk == 0) r.fk = k;
            if (done || err) begin r.tk = k; r.d = done; r.e = err; r.ae = rom_addr; end
            tick();
            k++;
        end
        start = 1'b0;
        r.n = issued.size() - n0;
        if (r.n > 0) begin r.fu = issued[n0]; r.lu = issued[$]; end
        r.post_clear = !done && !err && !busy;
    endtask

    vec_t vecs [4];
    res_t r;
    int   k, n0, d0, e0;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 20'hF_FFFF;
        rom[0] = U0; rom[1] = U1; rom[2] = U2; rom[3] = 20'h0_BEEF;
        rom[16] = U16; rom[17] = 20'h0_0000;
        rom[32] = 20'h0_1234;
        rom[60] = U60; rom[61] = 20'h7_003D; rom[62] = 20'h7_003E; rom[63] = U63;

        //             id     n  first last  done  err   fk  tk  addr0 addr_end
        vecs[0] = '{2'd0, 3, U0,  U2,  1'b1, 1'b0, 3, 15, 1'b1, 6'd3};
        vecs[1] = '{2'd1, 1, U16, U16, 1'b1, 1'b0, 3, 7,  1'b0, 6'd17};
        vecs[2] = '{2'd2, 0, '0,  '0,  1'b1, 1'b0, 0, 3,  1'b0, 6'd32};
        vecs[3] = '{2'd3, 4, U60, U63, 1'b0, 1'b1, 3, 17, 1'b0, 6'd63};

        rst = 1'b1; start = 1'b0; prog_id = 2'd0; uop_ready = 1'b1; force_done = 1'b0;
        start2 = 1'b0; prog_id2 = 2'd0; uop_ready2 = 1'b1; uop_done2 = 1'b0;
`ifdef UOP_SEQ_WATCHDOG_EN
        start3 = 1'b0; prog_id3 = 2'd0; uop_ready3 = 1'b1;
`endif
        repeat (3) tick();
        chk("reset_outputs", {busy, done, err, uop_valid, rom_addr, uop}, '0);
        rst = 1'b0;
        repeat (2) tick();

        // Table-driven program runs.
        for (int i = 0; i < 4; i++) begin
            run_prog(vecs[i].id, 0, r);
            chk($sformatf("v%0d_count", i), r.n, vecs[i].n);
            chk($sformatf("v%0d_first_k", i), r.fk, vecs[i].fk);
            chk($sformatf("v%0d_term_k", i), r.tk, vecs[i].tk);
            chk($sformatf("v%0d_done_err", i), {r.d, r.e}, {vecs[i].d, vecs[i].e});
            chk($sformatf("v%0d_busy1", i), r.busy1, 1'b1);
            chk($sformatf("v%0d_post_clear", i), r.post_clear, 1'b1);
            chk($sformatf("v%0d_addr0_seen", i), r.zero_seen, vecs[i].z);
            chk($sformatf("v%0d_addr_end", i), r.ae, vecs[i].ae);
            if (vecs[i].n > 0) begin
                chk($sformatf("v%0d_first_uop", i), r.fu, vecs[i].fu);
                chk($sformatf("v%0d_last_uop", i), r.lu, vecs[i].lu);
            end
            repeat (2) tick();
        end

        // Back-pressure on uop 1 for 5 cycles, with stray uop_done pulses.
        n0 = issued.size();
        start = 1'b1; prog_id = 2'd0;
        tick();
        start = 1'b0;
        k = 1;
        while (!(uop_valid && uop == U1) && k < 50) begin tick(); k++; end
        chk("stall_reach_k", k, 7);
        uop_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            force_done = (s == 1 || s == 3);
            chk($sformatf("stall_hold%0d", s), {uop_valid, uop, rom_addr}, {1'b1, U1, 6'd1});
            tick(); k++;
        end
        uop_ready = 1'b1; force_done = 1'b1;
        tick(); k++;
        force_done = 1'b0;
        while (!(done || err) && k < 80) begin tick(); k++; end
        chk("stall_term_k", k, 20);
        chk("stall_done_err", {done, err}, 2'b10);
        tick();
        chk("stall_count", issued.size() - n0, 3);
        if (issued.size() - n0 == 3) begin
            chk("stall_uop1", issued[n0+1], U1);
            chk("stall_uop2", issued[n0+2], U2);
        end
        repeat (2) tick();

        // start while busy is dropped and not queued.
        d0 = done_cnt;
        run_prog(2'd0, 5, r);
        chk("restart_term_k", r.tk, 15);
        chk("restart_count", r.n, 3);
        repeat (5) tick();
        chk("restart_no_queue", done_cnt - d0, 1);
        chk("restart_idle", busy, 1'b0);
        run_prog(2'd2, 0, r);
        chk("restart_later_term_k", r.tk, 3);
        chk("restart_later_done", {r.d, r.e}, 2'b10);
        repeat (2) tick();

        // Reset while waiting for uop_done.
        d0 = done_cnt; e0 = err_cnt;
        start = 1'b1; prog_id = 2'd0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("wait_state_seen", {busy, uop_valid, uop_done}, 3'b101);
        rst = 1'b1;
        tick();
        chk("rst_wait_out", {busy, done, err, uop_valid, rom_addr, uop}, '0);
        rst = 1'b0;
        repeat (4) tick();
        chk("rst_wait_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        chk("rst_wait_idle", busy, 1'b0);

        // Reset while a uop is being offered.
        start = 1'b1; prog_id = 2'd0;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("issue_state_seen", {busy, uop_valid}, 2'b11);
        rst = 1'b1;
        tick();
        chk("rst_issue_out", {busy, done, err, uop_valid}, 4'b0000);
        rst = 1'b0;
        repeat (2) tick();

        // Out-of-range prog_id on a 3-program build.
        prog_id2 = 2'd3; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("np3_bad_err", {err2, busy2, done2}, 3'b100);
        tick();
        chk("np3_bad_after", {err2, busy2}, 2'b00);
        prog_id2 = 2'd2; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("np3_ok_busy", busy2, 1'b1);
        repeat (2) tick();
        chk("np3_ok_done", {done2, err2, busy2, uop_valid2}, 4'b1000);
        tick();

`ifdef UOP_SEQ_WATCHDOG_EN
        // Watchdog limit 2 on a 3-uop program.
        n0 = issued3;
        start3 = 1'b1; prog_id3 = 2'd0;
        tick();
        start3 = 1'b0;
        k = 1;
        while (!(err3 || done3) && k < 60) begin tick(); k++; end
        chk("wdog_term_k", k, 11);
        chk("wdog_err", {err3, done3}, 2'b10);
        chk("wdog_count", issued3 - n0, 2);
        tick();
        chk("wdog_idle", busy3, 1'b0);
`endif

        chk("done_err_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
